// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves conditional branches one cycle after the ALU, computes
//            the branch target, keeps a direct-mapped table of 2-bit
//            saturating counters for decode-time prediction, and issues a
//            registered redirect (PC + flush) whenever the resolved outcome
//            disagrees with the prediction carried down the pipe.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int IMM_W     = 16,
  parameter int PHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic              dec_is_branch,
  input  logic [WIDTH-1:0]  dec_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [2:0]        ex_branch,
  input  logic              ex_zero,
  input  logic              ex_res_msb,
  input  logic [WIDTH-1:0]  ex_pc,
  input  logic [IMM_W-1:0]  ex_imm,
  input  logic              ex_pred_taken,
  input  logic              stall,
  output logic              redirect,
  output logic [WIDTH-1:0]  redirect_pc,
  output logic              ex_taken,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int IDX_W = (PHT_DEPTH > 1) ? $clog2(PHT_DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FIRE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_pht [PHT_DEPTH];
  logic [IDX_W-1:0]  w_dec_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic              w_accept;
  logic              w_taken;
  logic              w_mispredict;
  logic [WIDTH-1:0]  w_offset;
  logic [WIDTH-1:0]  w_fallthrough;
  logic [WIDTH-1:0]  w_target;
  logic              w_unused_dec_pc;

  // Only the index bits of the decode PC select a counter.
  assign w_unused_dec_pc = ^dec_pc;

  assign w_dec_idx = dec_pc[IDX_W+1:2];
  assign w_ex_idx  = ex_pc[IDX_W+1:2];

  // Word offset scaled to bytes; narrow PCs simply drop the upper imm bits.
  generate
    if (WIDTH > IMM_W + 2) begin : g_sext
      assign w_offset = {{(WIDTH-IMM_W-2){ex_imm[IMM_W-1]}}, ex_imm, 2'b00};
    end else begin : g_trunc
      logic [IMM_W+1:0] w_full;
      assign w_full   = {ex_imm, 2'b00};
      assign w_offset = w_full[WIDTH-1:0];
    end
  endgenerate

  assign w_fallthrough = ex_pc + WIDTH'(4);
  assign w_target      = w_fallthrough + w_offset;

  // Prediction reads the table before any same-cycle update lands.
  assign pred_taken = dec_valid & dec_is_branch & r_pht[w_dec_idx][1];

  // Branch condition decode from the opcode LSBs and ALU flags.
  always_comb begin
    w_taken = 1'b0;
    if (ex_branch[2]) begin
      case (ex_branch[1:0])
        2'b00:   w_taken = ex_zero;
        2'b01:   w_taken = ~ex_zero;
        2'b10:   w_taken = ex_zero | ex_res_msb;
        default: w_taken = ~ex_zero & ~ex_res_msb;
      endcase
    end
  end

  assign w_accept     = ex_valid & ~stall & ex_branch[2];
  assign w_mispredict = w_accept & (w_taken != ex_pred_taken);

  // Counter table: saturating 2-bit update on every accepted branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (w_accept) begin
      if (w_taken) begin
        if (r_pht[w_ex_idx] != 2'b11) r_pht[w_ex_idx] <= r_pht[w_ex_idx] + 2'b01;
      end else begin
        if (r_pht[w_ex_idx] != 2'b00) r_pht[w_ex_idx] <= r_pht[w_ex_idx] - 2'b01;
      end
    end
  end

  // Redirect FSM state register; reset kills a pulse immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: every mispredicting accept (re)enters FIRE for one cycle.
  always_comb begin
    w_state_next = ST_IDLE;
    if (w_mispredict) w_state_next = ST_FIRE;
  end

  assign redirect = (r_state == ST_FIRE);

  // Corrected PC, resolved outcome and saturating mispredict count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_pc      <= '0;
      ex_taken         <= 1'b0;
      mispredict_count <= '0;
    end else begin
      if (w_accept) ex_taken <= w_taken;
      if (w_mispredict) begin
        redirect_pc <= w_taken ? w_target : w_fallthrough;
        if (~&mispredict_count) mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed plus randomized self-checking bench for
//            branch_resolve_unit against a table-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;
  localparam int W  = 32;
  localparam int IW = 16;
  localparam int D  = 16;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dec_valid, dec_is_branch;
  logic [W-1:0]  dec_pc;
  logic          pred_taken;
  logic          ex_valid;
  logic [2:0]    ex_branch;
  logic          ex_zero, ex_res_msb;
  logic [W-1:0]  ex_pc;
  logic [IW-1:0] ex_imm;
  logic          ex_pred_taken;
  logic          stall;
  logic          redirect;
  logic [W-1:0]  redirect_pc;
  logic          ex_taken;
  logic [CW-1:0] mispredict_count;

  branch_resolve_unit #(.WIDTH(W), .IMM_W(IW), .PHT_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_is_branch(dec_is_branch), .dec_pc(dec_pc),
    .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_res_msb(ex_res_msb), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_pred_taken(ex_pred_taken), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .ex_taken(ex_taken),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_pht [D];
  int          m_cnt;
  logic [W-1:0] m_rpc;
  bit          m_tk;
  bit          m_red;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] br, input logic z, input logic m);
    if (!br[2]) return 1'b0;
    case (br[1:0])
      2'd0:    return z;
      2'd1:    return !z;
      2'd2:    return z || m;
      default: return !z && !m;
    endcase
  endfunction

  function automatic int pc_idx(input logic [W-1:0] pc);
    return int'((pc / 4) % D);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_pht[i] = 1;
    m_cnt = 0; m_rpc = '0; m_tk = 0; m_red = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_redirect"},    W'(redirect),         W'(m_red));
    chk({tag, "_redirect_pc"}, redirect_pc,          m_rpc);
    chk({tag, "_ex_taken"},    W'(ex_taken),         W'(m_tk));
    chk({tag, "_count"},       W'(mispredict_count), W'(m_cnt));
  endtask

  task automatic set_ex(input logic v, input logic [2:0] br, input logic z, input logic m,
                        input logic [W-1:0] pc, input logic [IW-1:0] imm,
                        input logic pt, input logic st);
    ex_valid = v; ex_branch = br; ex_zero = z; ex_res_msb = m;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = pt; stall = st;
  endtask

  task automatic idle_ex();
    set_ex(1'b0, 3'b000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // One clock: check the combinational prediction, clock, advance model, check.
  task automatic cycle(input string tag);
    bit acc, t;
    int ei, di, o;
    logic signed [IW-1:0] si;
    logic [W-1:0] tgt, ft;
    #1;
    di = pc_idx(dec_pc);
    chk({tag, "_pred"}, W'(pred_taken), W'(dec_valid && dec_is_branch && (m_pht[di] >= 2)));
    acc = ex_valid && !stall && ex_branch[2];
    t   = ref_taken(ex_branch, ex_zero, ex_res_msb);
    si  = ex_imm;
    o   = si;
    o   = o * 4;
    ft  = ex_pc + 32'd4;
    tgt = ft + W'(o);
    ei  = pc_idx(ex_pc);
    @(posedge clk);
    #1;
    m_red = 0;
    if (acc) begin
      m_tk = t;
      m_pht[ei] = t ? ((m_pht[ei] < 3) ? m_pht[ei] + 1 : 3)
                    : ((m_pht[ei] > 0) ? m_pht[ei] - 1 : 0);
      if (t != ex_pred_taken) begin
        m_red = 1;
        m_rpc = t ? tgt : ft;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    check_outputs(tag);
  endtask

  initial begin
    int saved;
    dec_valid = 0; dec_is_branch = 0; dec_pc = '0;
    idle_ex();
    model_reset();

    // Reset state
    #1 reset = 1'b1;
    #1 check_outputs("reset");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // Every index predicts not-taken after reset
    dec_valid = 1; dec_is_branch = 1;
    for (int i = 0; i < D; i++) begin
      dec_pc = W'(i * 4);
      #1 chk("reset_pred", W'(pred_taken), '0);
    end

    // Taken beq mispredict
    set_ex(1, 3'b100, 1, 0, 32'h100, 16'd3, 0, 0);
    cycle("beq_mis");
    chk("beq_redirect", W'(redirect), 32'd1);
    chk("beq_rpc", redirect_pc, 32'h110);
    chk("beq_cnt", W'(mispredict_count), 32'd1);
    idle_ex();
    cycle("beq_after");
    chk("beq_pulse_end", W'(redirect), 32'd0);

    // Not-taken bgtz mispredict
    set_ex(1, 3'b111, 0, 1, 32'h200, 16'd7, 1, 0);
    cycle("bgtz_mis");
    chk("bgtz_rpc", redirect_pc, 32'h204);
    chk("bgtz_taken", W'(ex_taken), 32'd0);

    // Async reset while the redirect pulse is active
    idle_ex();
    #2 reset = 1'b1;
    #1 chk("midfire_redirect", W'(redirect), 32'd0);
    chk("midfire_rpc", redirect_pc, 32'd0);
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    check_outputs("post_reset");

    // Counter training at 0x40
    dec_valid = 1; dec_is_branch = 1; dec_pc = 32'h40;
    #1 chk("train_init_pred", W'(pred_taken), 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 3'b100, 1, 0, 32'h40, 16'd1, m_pht[pc_idx(32'h40)] >= 2, 0);
      cycle("train_tk");
      idle_ex();
      #1 chk("train_tk_pred", W'(pred_taken), 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      set_ex(1, 3'b100, 0, 0, 32'h40, 16'd1, 1, 0);
      cycle("train_nt");
      idle_ex();
      #1 chk("train_nt_pred", W'(pred_taken), (i == 0) ? 32'd1 : 32'd0);
    end

    // Negative offset and address wrap
    set_ex(1, 3'b100, 1, 0, 32'h8, 16'hFFFC, 0, 0);
    cycle("neg_off");
    chk("neg_off_rpc", redirect_pc, 32'hFFFF_FFFC);
    set_ex(1, 3'b100, 0, 0, 32'hFFFF_FFFC, 16'd5, 1, 0);
    cycle("wrap_ft");
    chk("wrap_ft_rpc", redirect_pc, 32'h0);

    // Stall and non-branch produce no redirect
    idle_ex();
    cycle("pre_stall");
    saved = int'(mispredict_count);
    set_ex(1, 3'b100, 1, 0, 32'h80, 16'd2, 0, 1);
    cycle("stall");
    chk("stall_redirect", W'(redirect), 32'd0);
    chk("stall_cnt", W'(mispredict_count), W'(saved));
    set_ex(1, 3'b011, 1, 0, 32'h84, 16'd2, 1, 0);
    cycle("nonbranch");
    chk("nonbranch_redirect", W'(redirect), 32'd0);

    // Back-to-back mispredicts and count saturation
    for (int i = 0; i < 5; i++) begin
      set_ex(1, 3'b100, 1, 0, W'(32'h300 + i * 4), 16'd1, 0, 0);
      cycle("sat");
      chk("sat_redirect", W'(redirect), 32'd1);
    end
    chk("sat_count", W'(mispredict_count), 32'd3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_is_branch = $urandom_range(0, 1);
      dec_pc = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 63) * 4) : W'($urandom());
      set_ex($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 63) * 4) : W'($urandom()),
             IW'($urandom()), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
